barrel_shift_pipe: RTL
======================

// Module: barrel_shift_pipe
// PURPOSE
//  Pipelined, parametrised 2**N-bit barrel shifter/rotator with valid/ready handshake on both sides.
//  Supports four ops: SLL, SRL, SRA, ROL. The shamt is resolved one bit per pipeline stage.
//  Right shifts reuse the left-shift datapath via bit reversal at entry and exit.
//  Sits between operand source and ALU writeback; accepts one operation per cycle when unstalled.
// PARAMETERS
//  N   3   log2 of data width; W = 2**N bits (N >= 1); pipeline depth = N stages
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   input operation valid
//  in_ready   out  1   block can accept input this cycle
//  in_data    in   W   operand
//  in_shamt   in   N   shift amount 0..W-1
//  in_op      in   2   00 SLL, 01 SRL, 10 SRA, 11 ROL
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  out_data   out  W   result
//  out_carry  out  1   last bit shifted out (only with BSP_FLAGS_EN)
// BEHAVIOUR
//  - Reset: all stage valid bits, data, op, shamt and flag registers cleared; out_valid=0, out_data=0, out_carry=0.
//  - Global advance: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//  - A transfer occurs on in_valid & in_ready. Stage registers load only when adv=1.
//  - When adv=0, every stage holds. Bubbles are not collapsed.
//  - Entry (comb, before stage 0): SRL/SRA operands are bit-reversed; SLL/ROL pass straight.
//  - Fill bit f: 0 for SLL/SRL; for SRA, f = in_data[W-1] (sign), held through pipe.
//  - Stage k (k=0..N-1): if shamt[k], d = {d[W-1-2**k:0], fill}.
//    For ROL, fill = d[W-1 -: 2**k] (wrap); otherwise fill = {2**k{f}}.
//    Result is registered with its valid/op/shamt/f.
//  - Exit (comb, after stage N-1): SRL/SRA results are bit-reversed back, so out_data is the true right shift.
//  - Latency: exactly N cycles from accepted input to out_valid with out_ready held 1.
//    Throughput: 1 op/cycle.
//  - shamt=0: out_data = in_data for every op.
//  - shamt=W-1 boundary: SLL keeps only bit0 at MSB; SRL leaves original MSB at LSB; SRA yields all sign bits except LSB = MSB.
//  - Simultaneous input transfer and output drain in the same cycle are legal; no data loss or duplication.
//  - out_data/out_valid stay stable while out_valid & ~out_ready.
//  - Reset asserted mid-operation: all in-flight ops are discarded immediately (async); no output after release until new input.
//  - Illegal states: none; in_op is fully decoded.
// CONFIGURATION
//  - BSP_FLAGS_EN defined: port out_carry exists and is pipelined alongside data.
//      SLL: in_data[W-shamt]. SRL/SRA: in_data[shamt-1]. ROL: result bit0.
//      shamt=0: carry = 0 for all ops.
//  - BSP_FLAGS_EN undefined: out_carry port and its registers are absent. Data behaviour is identical.
// TESTING (N=3, W=8)
//  1. SLL 0x96 shamt 3, out_ready=1 -> out_data 0xB0 exactly 3 cycles later, out_carry 0.
//  2. SRA 0x96 shamt 2 -> out_data 0xE5, out_carry 1. Also SRL 0x81 shamt 7 -> out_data 0x01, out_carry 0.
//  3. ROL 0x96 shamt 3 -> 0xB4, out_carry 0. Also shamt 0 on all four ops -> out_data = in_data, carry 0.
//  4. Back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order.
//     Then hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable, no drops.
//  5. Assert reset with 3 ops in flight -> out_valid=0, out_data=0 immediately; no stale results after release.
//  6. Random op/shamt/data vs reference model, with random out_ready stalls, 10k ops -> zero mismatches.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: N-stage pipelined SLL/SRL/SRA/ROL barrel shifter with valid/ready handshake.
// Define BSP_FLAGS_EN to add the out_carry port and its flag pipeline.
module barrel_shift_pipe #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] in_data,
  input  logic [N-1:0]    in_shamt,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_data
`ifdef BSP_FLAGS_EN
  ,
  output logic            out_carry
`endif
);
  localparam int W = 2**N;
  logic         w_adv;
  logic [W-1:0] w_rev_in, w_rev_out;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;
  // right shifts run through the left-shift datapath on a bit-reversed operand
  always_comb
    for (int i = 0; i < W; i++) begin
      w_rev_in[i]  = in_data[W-1-i];
      w_rev_out[i] = g_st[N-1].r_d[W-1-i];
    end
  for (genvar k = 0; k < N; k++) begin : g_st
    localparam int S = 2**k;
    logic [W-1:0] w_di, w_sh, r_d;
    logic [N-1:k] w_si;
    logic [1:0]   w_oi, r_op;
    logic         w_vi, w_fi, r_v;
`ifdef BSP_FLAGS_EN
    logic         w_ci, w_cn, r_c;
`endif
    if (k == 0) begin : g_src
      assign w_di = (in_op[1] ^ in_op[0]) ? w_rev_in : in_data;
      assign w_si = in_shamt;
      assign w_oi = in_op;
      assign w_vi = in_valid;
      assign w_fi = (in_op == 2'b10) & in_data[W-1];
`ifdef BSP_FLAGS_EN
      assign w_ci = 1'b0;
`endif
    end else begin : g_src
      assign w_di = g_st[k-1].r_d;
      assign w_si = g_st[k-1].g_keep.r_sh;
      assign w_oi = g_st[k-1].r_op;
      assign w_vi = g_st[k-1].r_v;
      assign w_fi = g_st[k-1].g_keep.r_f;
`ifdef BSP_FLAGS_EN
      assign w_ci = g_st[k-1].r_c;
`endif
    end
    assign w_sh = w_si[k] ? {w_di[W-1-S:0], (w_oi == 2'b11) ? w_di[W-1 -: S] : {S{w_fi}}} : w_di;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_v  <= 1'b0;
        r_d  <= '0;
        r_op <= '0;
      end else if (w_adv) begin
        r_v  <= w_vi;
        r_d  <= w_sh;
        r_op <= w_oi;
      end
`ifdef BSP_FLAGS_EN
    // the last bit leaving the top is always at W-S before this stage's shift
    assign w_cn = w_si[k] ? w_di[W-S] : w_ci;
    always_ff @(posedge clk or posedge reset)
      if (reset) r_c <= 1'b0;
      else if (w_adv) r_c <= w_cn;
`endif
    if (k < N-1) begin : g_keep
      logic [N-1:k+1] r_sh;
      logic           r_f;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_sh <= '0;
          r_f  <= 1'b0;
        end else if (w_adv) begin
          r_sh <= w_si[N-1:k+1];
          r_f  <= w_fi;
        end
    end
  end
  assign out_valid = g_st[N-1].r_v;
  assign out_data  = (g_st[N-1].r_op[1] ^ g_st[N-1].r_op[0]) ? w_rev_out : g_st[N-1].r_d;
`ifdef BSP_FLAGS_EN
  assign out_carry = g_st[N-1].r_c;
`endif
endmodule
